debounce_controller: RTL and testbench

- Debounces N_CH mechanical push-buttons using one shared tick prescaler, so the channels do not need a divider each.
- Each channel has an input synchronizer and a 4-state FSM that accepts a level change only after STABLE_TICKS consecutive stable ticks.
- Outputs per channel: a clean level plus one-cycle press and release pulses for downstream logic (counters, FSM stepping, displays).

---
 rtl/debounce_controller_if.sv | 22 ++
 rtl/debounce_controller.sv | 141 ++++++++++++++
 tb/tb_debounce_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/debounce_controller_if.sv
// Button-side signal bundle for debounce_controller: raw inputs and enable in,
// debounced levels, edge pulses and the shared tick out.
interface debounce_controller_if #(
  parameter int unsigned N_CH = 4
);
  logic            enable;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic            tick_out;

  modport master (
    output enable, btn_in,
    input  btn_level, btn_press, btn_release, tick_out
  );

  modport slave (
    input  enable, btn_in,
    output btn_level, btn_press, btn_release, tick_out
  );
endinterface

// File: rtl/debounce_controller.sv
// N_CH push-button debouncer sharing one tick prescaler; each channel has a
// two-flop synchronizer and a 4-state check FSM with registered level/pulse outputs.
module debounce_controller #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned TICK_DIV     = 2000000,
  parameter int unsigned STABLE_TICKS = 4
) (
  input logic                  clk_in,
  input logic                  reset,
  debounce_controller_if.slave bus
);
  localparam int unsigned      PW       = $clog2(TICK_DIV);
  localparam int unsigned      CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0]    DIV_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  logic [PW-1:0]   div_q, div_d;
  logic            tick_q, tick_d;
  logic [N_CH-1:0] meta_q, sync_q;

  always_comb begin
    div_d  = '0;
    tick_d = 1'b0;
    if (bus.enable) begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      tick_d = (div_d == DIV_LAST);
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      meta_q <= bus.btn_in;
      sync_q <= meta_q;
    end
  end

  assign bus.tick_out = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (!bus.enable) begin
        // Pending checks fall back to the last accepted level; no pulses.
        cnt_d = '0;
        if (state_q == PRESS_CHK)   state_d = RELEASED;
        if (state_q == RELEASE_CHK) state_d = PRESSED;
      end else begin
        case (state_q)
          RELEASED: begin
            if (sync_q[g]) begin
              state_d = PRESS_CHK;
              cnt_d   = '0;
            end
          end
          PRESS_CHK: begin
            if (!sync_q[g]) begin
              state_d = RELEASED;
              cnt_d   = '0;
            end else if (tick_q) begin
              if (cnt_q == CNT_LAST) begin
                state_d = PRESSED;
                cnt_d   = '0;
                press_d = 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          PRESSED: begin
            if (!sync_q[g]) begin
              state_d = RELEASE_CHK;
              cnt_d   = '0;
            end
          end
          RELEASE_CHK: begin
            if (sync_q[g]) begin
              state_d = PRESSED;
              cnt_d   = '0;
            end else if (tick_q) begin
              if (cnt_q == CNT_LAST) begin
                state_d = RELEASED;
                cnt_d   = '0;
                rel_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_d = RELEASED;
            cnt_d   = '0;
          end
        endcase
      end
      level_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
    end

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign bus.btn_level[g]   = level_q;
    assign bus.btn_press[g]   = press_q;
    assign bus.btn_release[g] = rel_q;
  end
endmodule

// File: tb/tb_debounce_controller.sv
// Bench for debounce_controller: vector table plus hand sequences, with a
// queue of expected pulse events checked by a negedge monitor.
module tb_debounce_controller;
  localparam int unsigned N_CH         = 4;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned STABLE_TICKS = 3;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  debounce_controller_if #(.N_CH(N_CH)) bus ();

  debounce_controller #(
    .N_CH(N_CH),
    .TICK_DIV(TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
    int         lo;
    int         hi;
  } exp_t;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_evt(input logic [3:0] press, input logic [3:0] rel,
                            input logic [3:0] level, input int lo_off, input int hi_off);
    exp_t e;
    e.press = press;
    e.rel   = rel;
    e.level = level;
    e.lo    = cyc + lo_off;
    e.hi    = cyc + hi_off;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Any pulse must match the oldest expected event, in content and timing.
  always @(negedge clk_in) begin
    exp_t e;
    if ((bus.btn_press | bus.btn_release) != '0) begin
      check("press_release_overlap", 32'(bus.btn_press & bus.btn_release), 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got press=%0h release=%0h required none (cycle %0d)",
                 bus.btn_press, bus.btn_release, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_press", 32'(bus.btn_press), 32'(e.press));
        check("pulse_release", 32'(bus.btn_release), 32'(e.rel));
        check("pulse_level", 32'(bus.btn_level), 32'(e.level));
        tests++;
        if (cyc < e.lo || cyc > e.hi) begin
          fails++;
          $display("FAIL pulse_time: got cycle %0d required %0d..%0d", cyc, e.lo, e.hi);
        end
      end
    end
  end

  initial begin
    vec_t vec[7];
    int   n;

    vec[0] = '{btn: 4'b0001, press: 4'b0001, rel: 4'b0000, level: 4'b0001};
    vec[1] = '{btn: 4'b0000, press: 4'b0000, rel: 4'b0001, level: 4'b0000};
    vec[2] = '{btn: 4'b1111, press: 4'b1111, rel: 4'b0000, level: 4'b1111};
    vec[3] = '{btn: 4'b0000, press: 4'b0000, rel: 4'b1111, level: 4'b0000};
    vec[4] = '{btn: 4'b0110, press: 4'b0110, rel: 4'b0000, level: 4'b0110};
    vec[5] = '{btn: 4'b1010, press: 4'b1000, rel: 4'b0100, level: 4'b1010};
    vec[6] = '{btn: 4'b0000, press: 4'b0000, rel: 4'b1010, level: 4'b0000};

    bus.enable = 1'b1;
    bus.btn_in = '0;
    cycles(3);
    check("reset_level", 32'(bus.btn_level), 32'd0);
    check("reset_press", 32'(bus.btn_press), 32'd0);
    check("reset_release", 32'(bus.btn_release), 32'd0);
    check("reset_tick", 32'(bus.tick_out), 32'd0);
    reset = 1'b0;

    n = 0;
    while (!bus.tick_out && n < 20) begin
      cycles(1);
      n++;
    end
    check("tick_seen", 32'(bus.tick_out), 32'd1);
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin
        cycles(1);
        n++;
      end while (!bus.tick_out && n < 20);
      check("tick_period", 32'(n), 32'(TICK_DIV));
    end

    for (int i = 0; i < 7; i++) begin
      bus.btn_in = vec[i].btn;
      if ((vec[i].press | vec[i].rel) != '0)
        expect_evt(vec[i].press, vec[i].rel, vec[i].level, 11, 16);
      cycles(40);
      check("table_level", 32'(bus.btn_level), 32'(vec[i].level));
    end

    // Bounce on channel 1: 3-cycle segments never satisfy the window.
    for (int k = 0; k < 10; k++) begin
      bus.btn_in[1] = (k % 2 == 0);
      cycles(3);
    end
    bus.btn_in[1] = 1'b1;
    expect_evt(4'b0010, 4'b0000, 4'b0010, 11, 16);
    cycles(40);
    check("bounce_level", 32'(bus.btn_level), 32'h2);
    bus.btn_in = '0;
    expect_evt(4'b0000, 4'b0010, 4'b0000, 11, 16);
    cycles(40);

    // Release with a one-cycle glitch mid-check: the window restarts.
    bus.btn_in = 4'b0001;
    expect_evt(4'b0001, 4'b0000, 4'b0001, 11, 16);
    cycles(40);
    bus.btn_in = 4'b0000;
    cycles(8);
    bus.btn_in = 4'b0001;
    cycles(1);
    bus.btn_in = 4'b0000;
    expect_evt(4'b0000, 4'b0001, 4'b0000, 11, 16);
    cycles(40);
    check("glitch_level", 32'(bus.btn_level), 32'd0);

    // Disable during a press check: no ticks, no pulse, then a full new window.
    bus.btn_in = 4'b0100;
    cycles(6);
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      check("disabled_tick", 32'(bus.tick_out), 32'd0);
      check("disabled_level", 32'(bus.btn_level), 32'd0);
    end
    bus.enable = 1'b1;
    expect_evt(4'b0100, 4'b0000, 4'b0100, 10, 13);
    cycles(40);
    check("reenable_level", 32'(bus.btn_level), 32'h4);

    // Asynchronous reset between edges while channel 3 is mid-check.
    bus.btn_in = 4'b1100;
    cycles(6);
    @(posedge clk_in);
    #2;
    reset      = 1'b1;
    bus.btn_in = '0;
    #1;
    check("async_reset_level", 32'(bus.btn_level), 32'd0);
    check("async_reset_press", 32'(bus.btn_press), 32'd0);
    check("async_reset_release", 32'(bus.btn_release), 32'd0);
    check("async_reset_tick", 32'(bus.tick_out), 32'd0);
    cycles(3);
    reset = 1'b0;
    cycles(40);
    check("post_reset_level", 32'(bus.btn_level), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
